// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the stereo playback controller.
//   state_e    - playback sequencer states
//   SAMPLE_W   - DAC sample width
//   SILENCE    - excess-128 mid-scale code driven whenever playback is idle
//   apply_vol  - attenuates an excess-128 sample by an arithmetic right shift
package audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_L,
    ST_RD_R,
    ST_LATCH,
    ST_WAIT
  } state_e;

  // Re-centre on zero, shift (sign preserved), re-bias. The clamp keeps the
  // result inside the unsigned DAC range.
  function automatic logic [SAMPLE_W-1:0] apply_vol(input logic [SAMPLE_W-1:0] s,
                                                    input logic [2:0] vol);
    logic signed [8:0] d;
    logic signed [9:0] r;
    d = $signed({1'b0, s}) - 9'sd128;
    d = d >>> vol;
    r = $signed({d[8], d}) + 10'sd128;
    if (r < 10'sd0)        return 8'h00;
    else if (r > 10'sd255) return 8'hFF;
    else                   return r[7:0];
  endfunction

endpackage

// File: rtl/audio_prescaler.sv
// audio_prescaler: sample-rate prescaler.
//   clk, Reset  - system clock, synchronous active-high reset
//   clr_i       - synchronous clear to 0 (wins over en_i)
//   en_i        - count enable
//   tick_o      - high while the count sits at CLK_DIV-1
module audio_prescaler #(
  parameter int CLK_DIV = 7000
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (Reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == TC);

endmodule

// File: rtl/audio_playback_ctrl.sv
// audio_playback_ctrl: stereo sample playback sequencer.
// Reads a left and a right sample per period from one shared memory port and
// publishes both to the DAC registers together with a one-cycle strobe.
//
// Optional build macro: AUDIO_VOLUME_EN adds vol_l_i / vol_r_i (3-bit shift
// attenuation applied as the pair is latched).
//
// Ports:
//   clk, Reset            - system clock, synchronous active-high reset
//   cmd_start_i/stop_i    - start / stop command pulses (stop wins)
//   cmd_loop_i, cmd_base_i, cmd_len_i - run setup, captured on accepted start
//   busy_o, done_o        - run active / non-loop run finished pulse
//   mem_rd_o, mem_addr_o, mem_data_i  - sample memory port, 1-cycle read latency
//   sample_l_o, sample_r_o, sample_strobe_o - DAC sample pair and update strobe
//
// state    | meaning
// IDLE     | outputs silent, waiting for a start with nonzero length
// RD_L     | left-bank read issued
// RD_R     | right-bank read issued, left data captured into shadow
// LATCH    | pair published, index advanced or run ended
// WAIT     | prescaler runs out the remainder of the sample period
module audio_playback_ctrl
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 7000,
  parameter int ADDR_W     = 12,
  parameter int STEREO_OFS = 2000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_start_i,
  input  logic              cmd_stop_i,
  input  logic              cmd_loop_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]        vol_l_i,
  input  logic [2:0]        vol_r_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        sample_l_o,
  output logic [7:0]        sample_r_o,
  output logic              sample_strobe_o
);

  localparam logic [ADDR_W-1:0] R_OFS = ADDR_W'(STEREO_OFS);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q, len_q, idx_q, mem_addr_q;
  logic              loop_q, busy_q, done_q, mem_rd_q, strobe_q;
  logic [7:0]        shadow_q, sample_l_q, sample_r_q;
  logic [7:0]        sample_l_d, sample_r_d;
  logic              tick;

  // Prescaler is held at 0 in IDLE and restarted on each WAIT->RD_L, so it
  // reads 0 in RD_L and reaches CLK_DIV-1 exactly one period later.
  audio_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk    (clk),
    .Reset  (Reset),
    .clr_i  ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && tick)),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
`ifdef AUDIO_VOLUME_EN
    sample_l_d = apply_vol(shadow_q, vol_l_i);
    sample_r_d = apply_vol(mem_data_i, vol_r_i);
`else
    sample_l_d = shadow_q;
    sample_r_d = mem_data_i;
`endif
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      loop_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      shadow_q   <= SILENCE;
      sample_l_q <= SILENCE;
      sample_r_q <= SILENCE;
      strobe_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      if (cmd_stop_i && (state_q != ST_IDLE)) begin
        // Abort: any read in flight is simply never consumed.
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        mem_rd_q   <= 1'b0;
        mem_addr_q <= '0;
        sample_l_q <= SILENCE;
        sample_r_q <= SILENCE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // The final pair of a run is shown for its one strobe cycle and
            // then returns to silence here.
            sample_l_q <= SILENCE;
            sample_r_q <= SILENCE;
            mem_rd_q   <= 1'b0;
            if (cmd_start_i && !cmd_stop_i && (cmd_len_i != '0)) begin
              base_q     <= cmd_base_i;
              len_q      <= cmd_len_i;
              loop_q     <= cmd_loop_i;
              idx_q      <= '0;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= cmd_base_i;
              state_q    <= ST_RD_L;
            end
          end
          ST_RD_L: begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= base_q + R_OFS + idx_q;
            state_q    <= ST_RD_R;
          end
          ST_RD_R: begin
            shadow_q <= mem_data_i;
            mem_rd_q <= 1'b0;
            state_q  <= ST_LATCH;
          end
          ST_LATCH: begin
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            strobe_q   <= 1'b1;
            if (idx_q == len_q - ADDR_W'(1)) begin
              if (loop_q) begin
                idx_q   <= '0;
                state_q <= ST_WAIT;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (tick) begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= base_q + idx_q;
              state_q    <= ST_RD_L;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign mem_rd_o        = mem_rd_q;
  assign mem_addr_o      = mem_addr_q;
  assign sample_l_o      = sample_l_q;
  assign sample_r_o      = sample_r_q;
  assign sample_strobe_o = strobe_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
module tb_audio_playback_ctrl;

  localparam int CLK_DIV = 8;
  localparam int ADDR_W  = 12;
  localparam int OFS     = 2000;

  logic              clk = 1'b0;
  logic              Reset;
  logic              cmd_start, cmd_stop, cmd_loop;
  logic [ADDR_W-1:0] cmd_base, cmd_len;
  logic              busy, done, mem_rd, strobe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data, sample_l, sample_r;
`ifdef AUDIO_VOLUME_EN
  logic [2:0]        vol_l, vol_r;
`endif

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    int         at_cyc;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    bit                b2b;
    logic [7:0]        l0;
    logic [7:0]        r0;
  } run_t;

  exp_t              sb[$];
  logic [ADDR_W-1:0] laddr_q[$];
  logic [7:0]        mem [0:4095];
  run_t              runs[4];
  int                total = 0, bad = 0, cyc = 0, done_cnt = 0;
  int                dc;

  audio_playback_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .STEREO_OFS(OFS)) dut (
    .clk             (clk),
    .Reset           (Reset),
    .cmd_start_i     (cmd_start),
    .cmd_stop_i      (cmd_stop),
    .cmd_loop_i      (cmd_loop),
    .cmd_base_i      (cmd_base),
    .cmd_len_i       (cmd_len),
`ifdef AUDIO_VOLUME_EN
    .vol_l_i         (vol_l),
    .vol_r_i         (vol_r),
`endif
    .busy_o          (busy),
    .done_o          (done),
    .mem_rd_o        (mem_rd),
    .mem_addr_o      (mem_addr),
    .mem_data_i      (mem_data),
    .sample_l_o      (sample_l),
    .sample_r_o      (sample_r),
    .sample_strobe_o (strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops on each strobe, done counting, left-read address log.
  initial begin
    logic rd_prev;
    exp_t e;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mem_rd && !rd_prev) laddr_q.push_back(mem_addr);
      rd_prev = mem_rd;
      if (strobe) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got l=%0h r=%0h want none (cyc %0d)", sample_l, sample_r, cyc);
        end else begin
          e = sb.pop_front();
          check("strobe_l", 16'(sample_l), 16'(e.l));
          check("strobe_r", 16'(sample_r), 16'(e.r));
          check("strobe_cyc", 16'(cyc), 16'(e.at_cyc));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected pairs for n strobes; start must be driven right after this call.
  task automatic push_run(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                          input int n, input logic [7:0] l0, input logic [7:0] r0);
    exp_t e;
    logic [ADDR_W-1:0] la, ra;
    for (int i = 0; i < n; i++) begin
      la = base + ADDR_W'(i % int'(len));
      ra = la + ADDR_W'(OFS);
      e.l = (i == 0) ? l0 : mem[la];
      e.r = (i == 0) ? r0 : mem[ra];
      e.at_cyc = cyc + 1 + 3 + i * CLK_DIV;
      sb.push_back(e);
    end
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len, input logic lp);
    cmd_start = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    cmd_loop  = lp;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check(name, 16'(done), 16'd1);
  endtask

  task automatic wait_sb(input string name, input int left);
    int n;
    n = 0;
    while (sb.size() > left && n < 300) begin
      tick();
      n++;
    end
    check(name, 16'(sb.size()), 16'(left));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 16'(busy), 16'd0);
    check({name, "_done"}, 16'(done), 16'd0);
    check({name, "_rd"}, 16'(mem_rd), 16'd0);
    check({name, "_l"}, 16'(sample_l), 16'h80);
    check({name, "_r"}, 16'(sample_r), 16'h80);
    check({name, "_strobe"}, 16'(strobe), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    Reset = 1'b1;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_loop  = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
`ifdef AUDIO_VOLUME_EN
    vol_l = 3'd0;
    vol_r = 3'd0;
`endif
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
    runs[0] = '{12'h010, 12'd3, 1'b0, 8'h10, 8'hE0};
    runs[1] = '{12'h100, 12'd2, 1'b1, 8'h00, 8'hD0};
    runs[2] = '{12'hFFF, 12'd2, 1'b0, 8'hFF, 8'hCF};
    runs[3] = '{12'h850, 12'd1, 1'b1, 8'h50, 8'h20};

    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_addr", 16'(mem_addr), 16'd0);
    Reset = 1'b0;
    tick();

    // Table-driven runs; b2b entries start in the previous run's done cycle.
    dc = done_cnt;
    for (int i = 0; i < 4; i++) begin
      push_run(runs[i].base, runs[i].len, int'(runs[i].len), runs[i].l0, runs[i].r0);
      start(runs[i].base, runs[i].len, 1'b0);
      check("run_busy", 16'(busy), 16'd1);
      wait_done("run_done_seen");
      check("run_done_busy", 16'(busy), 16'd0);
      if (i == 3 || !runs[i+1].b2b) begin
        tick();
        check_idle_outputs("run_after");
      end
    end
    check("run_done_count", 16'(done_cnt - dc), 16'd4);
    check("run_sb_empty", 16'(sb.size()), 16'd0);

    // Loop wrap across the top of the address space, then stop during RD_R.
    tick();
    laddr_q.delete();
    dc = done_cnt;
    push_run(12'hFFE, 12'd4, 6, 8'hFE, 8'hCE);
    start(12'hFFE, 12'd4, 1'b1);
    wait_sb("loop_strobes", 0);
    check("loop_a0", 16'(laddr_q[0]), 16'hFFE);
    check("loop_a1", 16'(laddr_q[1]), 16'hFFF);
    check("loop_a2", 16'(laddr_q[2]), 16'h000);
    check("loop_a3", 16'(laddr_q[3]), 16'h001);
    check("loop_a4", 16'(laddr_q[4]), 16'hFFE);
    check("loop_busy", 16'(busy), 16'd1);
    check("loop_no_done", 16'(done_cnt - dc), 16'd0);
    n = 0;
    while (!(mem_rd && mem_addr == 12'h7D0) && n < 50) begin
      tick();
      n++;
    end
    check("stop_found_rdr", 16'(mem_rd && mem_addr == 12'h7D0), 16'd1);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    check_idle_outputs("stop");
    repeat (20) tick();
    check("stop_no_done", 16'(done_cnt - dc), 16'd0);
    check("stop_busy_later", 16'(busy), 16'd0);

    // Command conflicts.
    cmd_stop = 1'b1;
    start(12'h010, 12'd3, 1'b0);
    cmd_stop = 1'b0;
    check("startstop_busy", 16'(busy), 16'd0);
    check("startstop_rd", 16'(mem_rd), 16'd0);
    start(12'h010, 12'd0, 1'b0);
    check("len0_busy", 16'(busy), 16'd0);
    check("len0_rd", 16'(mem_rd), 16'd0);
    repeat (10) tick();

    dc = done_cnt;
    push_run(12'h300, 12'd3, 3, 8'h00, 8'hD0);
    start(12'h300, 12'd3, 1'b0);
    repeat (2) tick();
    start(12'h500, 12'd5, 1'b1);
    wait_done("busy_start_done_seen");
    check("busy_start_sb", 16'(sb.size()), 16'd0);
    tick();
    check("busy_start_done_count", 16'(done_cnt - dc), 16'd1);
    check("busy_start_idle", 16'(busy), 16'd0);

    // Reset while in WAIT (the cycle the first strobe is visible).
    push_run(12'h020, 12'd3, 3, 8'h20, 8'hF0);
    start(12'h020, 12'd3, 1'b0);
    wait_sb("rst_first_strobe", 2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle_outputs("rst");
    check("rst_addr", 16'(mem_addr), 16'd0);
    sb.delete();
    tick();
    dc = done_cnt;
    push_run(12'h020, 12'd2, 2, 8'h20, 8'hF0);
    start(12'h020, 12'd2, 1'b0);
    wait_done("rst_fresh_done_seen");
    tick();
    check("rst_fresh_done_count", 16'(done_cnt - dc), 16'd1);
    check("rst_fresh_sb", 16'(sb.size()), 16'd0);

`ifdef AUDIO_VOLUME_EN
    mem[12'h040] = 8'hC0;
    mem[12'h810] = 8'h00;
    vol_l = 3'd1;
    vol_r = 3'd7;
    push_run(12'h040, 12'd1, 1, 8'hA0, 8'h7F);
    start(12'h040, 12'd1, 1'b0);
    wait_done("vol_done_seen");
    tick();
    check("vol_sb", 16'(sb.size()), 16'd0);
    vol_l = 3'd0;
    vol_r = 3'd0;
`endif

    repeat (5) tick();
    check("final_sb_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
